// File: rtl/cue_aim_controller_if.sv
// Signal bundle between the keyboard decoder, white-ball object, line drawer and the cue aim controller.
// The controller binds the slave modport; the surrounding blocks drive through master.
interface cue_aim_controller_if;
  logic               startOfFrame;
  logic               keyLeft;
  logic               keyRight;
  logic               keyUp;
  logic               keyDown;
  logic               keyEnter;
  logic               ballsMoving;
  logic signed [10:0] whiteBallPosX;
  logic signed [10:0] whiteBallPosY;
  logic               lineEnable;
  logic signed [10:0] lineTopLeftPosX;
  logic signed [10:0] lineTopLeftPosY;
  logic signed [10:0] velocityX;
  logic signed [10:0] velocityY;
  logic               shotValid;
  logic signed [10:0] shotVelocityX;
  logic signed [10:0] shotVelocityY;

  modport master (
    output startOfFrame, keyLeft, keyRight, keyUp, keyDown, keyEnter,
           ballsMoving, whiteBallPosX, whiteBallPosY,
    input  lineEnable, lineTopLeftPosX, lineTopLeftPosY, velocityX, velocityY,
           shotValid, shotVelocityX, shotVelocityY
  );

  modport slave (
    input  startOfFrame, keyLeft, keyRight, keyUp, keyDown, keyEnter,
           ballsMoving, whiteBallPosX, whiteBallPosY,
    output lineEnable, lineTopLeftPosX, lineTopLeftPosY, velocityX, velocityY,
           shotValid, shotVelocityX, shotVelocityY
  );
endinterface

// File: rtl/cue_aim_controller.sv
// Per-turn cue sequencer: settle -> aim (arrow-key steering) -> one-cycle shot -> wait for motion.
// All outputs registered; one clock from input to output, no backpressure on the shot strobe.
module cue_aim_controller #(
  parameter int AIM_STEP      = 4,
  parameter int MAX_VEC       = 200,
  parameter int DEFAULT_VX    = 64,
  parameter int DEFAULT_VY    = 0,
  parameter int SHOT_SHIFT    = 2,
  parameter int MOVE_TIMEOUT  = 8,
  parameter int SETTLE_FRAMES = 4
) (
  input logic                 clk,
  input logic                 resetN,
  cue_aim_controller_if.slave bus
);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_AIM    = 2'd1;
  localparam logic [1:0] ST_FIRE   = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam logic signed [11:0] STEP  = 12'(AIM_STEP);
  localparam logic signed [11:0] V_MAX = 12'(MAX_VEC);
  localparam logic signed [11:0] V_MIN = -12'(MAX_VEC);
  localparam logic [7:0] SETTLE_N  = 8'(SETTLE_FRAMES);
  localparam logic [7:0] TIMEOUT_N = 8'(MOVE_TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               enter_prev_q, enter_prev_d;
  logic               line_en_q, line_en_d;
  logic signed [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0] vx_q, vx_d, vy_q, vy_d;
  logic               shot_vld_q, shot_vld_d;
  logic signed [10:0] svx_q, svx_d, svy_q, svy_d;

  logic               enter_rise;
  logic [7:0]         cnt_inc;
  logic signed [11:0] dx, dy, sum_x, sum_y;

  function automatic logic signed [10:0] clamp(input logic signed [11:0] v);
    logic signed [11:0] r;
    if (v > V_MAX)      r = V_MAX;
    else if (v < V_MIN) r = V_MIN;
    else                r = v;
    return $signed(r[10:0]);
  endfunction

  assign enter_rise = bus.keyEnter & ~enter_prev_q;
  assign cnt_inc    = cnt_q + 8'd1;

  // Opposing arrows cancel; the sum is widened so the clamp sees the true overshoot.
  always_comb begin
    dx = 12'sd0;
    dy = 12'sd0;
    if (bus.keyRight && !bus.keyLeft)      dx = STEP;
    else if (bus.keyLeft && !bus.keyRight) dx = -STEP;
    if (bus.keyDown && !bus.keyUp)         dy = STEP;
    else if (bus.keyUp && !bus.keyDown)    dy = -STEP;
    sum_x = {vx_q[10], vx_q} + dx;
    sum_y = {vy_q[10], vy_q} + dy;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_prev_d = bus.keyEnter;
    line_en_d    = line_en_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    shot_vld_d   = 1'b0;
    svx_d        = svx_q;
    svy_d        = svy_q;

    case (state_q)
      ST_SETTLE: begin
        line_en_d = 1'b0;
        if (bus.startOfFrame) begin
          if (bus.ballsMoving) begin
            cnt_d = 8'd0;
          end else if (cnt_inc >= SETTLE_N) begin
            state_d   = ST_AIM;
            cnt_d     = 8'd0;
            line_en_d = 1'b1;
            vx_d      = 11'(DEFAULT_VX);
            vy_d      = 11'(DEFAULT_VY);
            pos_x_d   = bus.whiteBallPosX;
            pos_y_d   = bus.whiteBallPosY;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_AIM: begin
        line_en_d = 1'b1;
        // A fire takes priority over a coincident frame, so the shot uses the pre-update vector.
        if (enter_rise && (vx_q != 11'sd0 || vy_q != 11'sd0)) begin
          state_d    = ST_FIRE;
          line_en_d  = 1'b0;
          shot_vld_d = 1'b1;
          svx_d      = vx_q >>> SHOT_SHIFT;
          svy_d      = vy_q >>> SHOT_SHIFT;
        end else if (bus.startOfFrame) begin
          pos_x_d = bus.whiteBallPosX;
          pos_y_d = bus.whiteBallPosY;
          vx_d    = clamp(sum_x);
          vy_d    = clamp(sum_y);
        end
      end

      ST_FIRE: begin
        state_d   = ST_WAIT;
        cnt_d     = 8'd0;
        line_en_d = 1'b0;
      end

      ST_WAIT: begin
        line_en_d = 1'b0;
        if (bus.ballsMoving) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd0;
        end else if (bus.startOfFrame) begin
          if (cnt_inc >= TIMEOUT_N) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d   = ST_SETTLE;
        cnt_d     = 8'd0;
        line_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_SETTLE;
      cnt_q        <= 8'd0;
      enter_prev_q <= 1'b1;
      line_en_q    <= 1'b0;
      pos_x_q      <= 11'sd0;
      pos_y_q      <= 11'sd0;
      vx_q         <= 11'(DEFAULT_VX);
      vy_q         <= 11'(DEFAULT_VY);
      shot_vld_q   <= 1'b0;
      svx_q        <= 11'sd0;
      svy_q        <= 11'sd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      enter_prev_q <= enter_prev_d;
      line_en_q    <= line_en_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      shot_vld_q   <= shot_vld_d;
      svx_q        <= svx_d;
      svy_q        <= svy_d;
    end
  end

  assign bus.lineEnable      = line_en_q;
  assign bus.lineTopLeftPosX = pos_x_q;
  assign bus.lineTopLeftPosY = pos_y_q;
  assign bus.velocityX       = vx_q;
  assign bus.velocityY       = vy_q;
  assign bus.shotValid       = shot_vld_q;
  assign bus.shotVelocityX   = svx_q;
  assign bus.shotVelocityY   = svy_q;

endmodule

// File: tb/tb_cue_aim_controller.sv
// Bench for cue_aim_controller: directed turns; shots are checked against a queue of expected velocities.
module tb_cue_aim_controller;

  logic clk = 1'b0;
  logic resetN;
  logic rst2_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct { int vx; int vy; } shot_t;
  shot_t q1[$];
  shot_t q2[$];

  cue_aim_controller_if ifc ();
  cue_aim_controller_if ifc2 ();

  always #5 clk = ~clk;

  cue_aim_controller u_dut (.clk(clk), .resetN(resetN), .bus(ifc.slave));

  // Second instance starts from an odd vector so the sign-preserving shift is observable.
  cue_aim_controller #(.DEFAULT_VX(-37), .DEFAULT_VY(100)) u_dut2 (
    .clk(clk), .resetN(rst2_n), .bus(ifc2.slave));

  assign ifc2.startOfFrame  = ifc.startOfFrame;
  assign ifc2.keyLeft       = ifc.keyLeft;
  assign ifc2.keyRight      = ifc.keyRight;
  assign ifc2.keyUp         = ifc.keyUp;
  assign ifc2.keyDown       = ifc.keyDown;
  assign ifc2.keyEnter      = ifc.keyEnter;
  assign ifc2.ballsMoving   = ifc.ballsMoving;
  assign ifc2.whiteBallPosX = ifc.whiteBallPosX;
  assign ifc2.whiteBallPosY = ifc.whiteBallPosY;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every observed shot must match the head of its queue.
  logic prev1 = 1'b0;
  always @(negedge clk) begin
    if (ifc.shotValid) begin
      checks++;
      if (prev1) begin
        errors++;
        $display("FAIL shot_back_to_back: shotValid high on consecutive cycles");
      end
      chk("shot_line_off", int'(ifc.lineEnable), 0);
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_shot: vx %0d vy %0d with none expected",
                 ifc.shotVelocityX, ifc.shotVelocityY);
      end else begin
        shot_t e;
        e = q1.pop_front();
        chk("shot_vx", int'(ifc.shotVelocityX), e.vx);
        chk("shot_vy", int'(ifc.shotVelocityY), e.vy);
      end
    end
    prev1 = ifc.shotValid;
  end

  always @(negedge clk) begin
    if (ifc2.shotValid) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_shot2: vx %0d vy %0d with none expected",
                 ifc2.shotVelocityX, ifc2.shotVelocityY);
      end else begin
        shot_t e;
        e = q2.pop_front();
        chk("shot2_vx", int'(ifc2.shotVelocityX), e.vx);
        chk("shot2_vy", int'(ifc2.shotVelocityY), e.vy);
      end
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ifc.startOfFrame = 1'b1;
      @(posedge clk); #1 ifc.startOfFrame = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic press_enter();
    @(posedge clk); #1 ifc.keyEnter = 1'b1;
    @(posedge clk); #1 ifc.keyEnter = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push1(input int vx, input int vy);
    shot_t s;
    s.vx = vx; s.vy = vy;
    q1.push_back(s);
  endtask

  task automatic check_aim_entry(input string tag);
    frames(3);
    chk({tag, "_still_settling"}, int'(ifc.lineEnable), 0);
    frames(1);
    chk({tag, "_line_en"}, int'(ifc.lineEnable), 1);
  endtask

  initial begin
    shot_t s;
    resetN = 1'b0;
    rst2_n = 1'b0;
    ifc.startOfFrame = 1'b0;
    ifc.keyLeft = 1'b0; ifc.keyRight = 1'b0; ifc.keyUp = 1'b0; ifc.keyDown = 1'b0;
    ifc.keyEnter = 1'b0;
    ifc.ballsMoving = 1'b0;
    ifc.whiteBallPosX = 11'sd300;
    ifc.whiteBallPosY = 11'sd200;
    #22;
    chk("rst_line_en", int'(ifc.lineEnable), 0);
    chk("rst_shot_vld", int'(ifc.shotValid), 0);
    chk("rst_vx", int'(ifc.velocityX), 64);
    chk("rst_vy", int'(ifc.velocityY), 0);
    chk("rst_pos_x", int'(ifc.lineTopLeftPosX), 0);
    chk("rst_shot_vx", int'(ifc.shotVelocityX), 0);
    resetN = 1'b1;
    rst2_n = 1'b1;

    check_aim_entry("arm1");
    chk("arm1_vx", int'(ifc.velocityX), 64);
    chk("arm1_vy", int'(ifc.velocityY), 0);
    chk("arm1_pos_x", int'(ifc.lineTopLeftPosX), 300);
    chk("arm1_pos_y", int'(ifc.lineTopLeftPosY), 200);

    // Both instances fire together: (64,0)>>>2 and (-37,100)>>>2.
    push1(16, 0);
    s.vx = -10; s.vy = 25; q2.push_back(s);
    press_enter();
    chk("post_shot_line_en", int'(ifc.lineEnable), 0);
    chk("post_shot_shot_vx_held", int'(ifc.shotVelocityX), 16);
    rst2_n = 1'b0;

    // No motion after the shot: timeout to SETTLE, then the settle count.
    ifc.whiteBallPosX = 11'sd120;
    ifc.whiteBallPosY = -11'sd50;
    frames(7);
    chk("timeout_wait", int'(ifc.lineEnable), 0);
    frames(1);
    check_aim_entry("timeout");
    chk("timeout_pos_x", int'(ifc.lineTopLeftPosX), 120);
    chk("timeout_pos_y", int'(ifc.lineTopLeftPosY), -50);

    ifc.keyRight = 1'b1; ifc.keyUp = 1'b1;
    frames(10);
    chk("steer_vx", int'(ifc.velocityX), 104);
    chk("steer_vy", int'(ifc.velocityY), -40);
    ifc.keyUp = 1'b0;
    ifc.whiteBallPosX = 11'sd77;
    ifc.whiteBallPosY = 11'sd33;
    frames(50);
    chk("clamp_hi_vx", int'(ifc.velocityX), 200);
    chk("clamp_vy_hold", int'(ifc.velocityY), -40);
    chk("relatch_pos_x", int'(ifc.lineTopLeftPosX), 77);
    chk("relatch_pos_y", int'(ifc.lineTopLeftPosY), 33);
    ifc.keyLeft = 1'b1;
    frames(3);
    chk("both_keys_vx", int'(ifc.velocityX), 200);
    ifc.keyRight = 1'b0;
    frames(110);
    chk("clamp_lo_vx", int'(ifc.velocityX), -200);
    ifc.keyLeft = 1'b0; ifc.keyRight = 1'b1;
    frames(50);
    ifc.keyRight = 1'b0; ifc.keyDown = 1'b1;
    frames(10);
    ifc.keyDown = 1'b0;
    chk("zero_vx", int'(ifc.velocityX), 0);
    chk("zero_vy", int'(ifc.velocityY), 0);
    press_enter();
    chk("zero_enter_ignored", int'(ifc.lineEnable), 1);

    // Enter rise on a frame pulse with keyDown held: shot from (8,0), not (8,4).
    ifc.keyRight = 1'b1;
    frames(2);
    ifc.keyRight = 1'b0; ifc.keyDown = 1'b1;
    push1(2, 0);
    @(posedge clk); #1 ifc.keyEnter = 1'b1; ifc.startOfFrame = 1'b1;
    @(posedge clk); #1 ifc.keyEnter = 1'b0; ifc.startOfFrame = 1'b0;
    ifc.keyDown = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("coinc_vx_held", int'(ifc.velocityX), 8);
    chk("coinc_vy_held", int'(ifc.velocityY), 0);

    // Motion starts two frames after the shot; a lone still frame must not finish the settle.
    frames(2);
    ifc.ballsMoving = 1'b1;
    frames(30);
    chk("moving_line_en", int'(ifc.lineEnable), 0);
    ifc.ballsMoving = 1'b0;
    frames(2);
    ifc.ballsMoving = 1'b1;
    frames(1);
    ifc.ballsMoving = 1'b0;
    check_aim_entry("settle");
    chk("settle_vx_default", int'(ifc.velocityX), 64);

    // Enter held through reset must not fire until released and pressed again.
    ifc.keyEnter = 1'b1;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    check_aim_entry("held_enter");
    ifc.keyEnter = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("held_enter_no_shot_q", q1.size(), 0);
    push1(16, 0);
    press_enter();
    frames(8);
    check_aim_entry("rearm");

    // Reset asserted inside the FIRE cycle clears the strobe at once.
    @(posedge clk); #1 ifc.keyEnter = 1'b1;
    @(posedge clk); #1 ifc.keyEnter = 1'b0;
    chk("fire_cycle_vld", int'(ifc.shotValid), 1);
    #1 resetN = 1'b0;
    #1;
    chk("fire_rst_vld", int'(ifc.shotValid), 0);
    chk("fire_rst_line_en", int'(ifc.lineEnable), 0);
    chk("fire_rst_shot_vx", int'(ifc.shotVelocityX), 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    check_aim_entry("post_fire_rst");

    repeat (5) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cue_aim_controller.md
Name: cue_aim_controller

Overview:
Sequences the cue direction line and the shot for one player turn. Accepts frame-rate key input to steer an aim vector. Feeds the direction line drawer with its anchor position, aim vector and enable. Issues a single shot pulse to the ball physics block, then waits for the table to settle before re-arming. Sits between the keyboard decoder, the white-ball object and the direction line drawer.

Parameters:
AIM_STEP, 4, aim-vector change per frame per held arrow key (pixels)
MAX_VEC, 200, clamp bound for each aim component (magnitude)
DEFAULT_VX, 64, aim X loaded on every entry to AIM
DEFAULT_VY, 0, aim Y loaded on every entry to AIM
SHOT_SHIFT, 2, arithmetic right shift applied to aim vector to form shot velocity
MOVE_TIMEOUT, 8, frames to wait for ballsMoving after a shot
SETTLE_FRAMES, 4, consecutive still frames required before re-arming

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
keyLeft, keyRight, keyUp, keyDown  in  1 each  level, arrow held
keyEnter  in  1  level, Enter held
ballsMoving  in  1  level, any ball has nonzero velocity
whiteBallPosX, whiteBallPosY  in  11 signed each  white ball top-left
lineEnable  out  1  direction line drawer enable
lineTopLeftPosX, lineTopLeftPosY  out  11 signed each  line anchor (latched ball top-left)
velocityX, velocityY  out  11 signed each  aim vector to line drawer
shotValid  out  1  one-cycle shot strobe
shotVelocityX, shotVelocityY  out  11 signed each  shot velocity, valid with shotValid

Behaviour:
- All outputs registered. Reset is asynchronous, active-low. Reset values:
  - state=SETTLE; lineEnable=0; shotValid=0.
  - velocity=(DEFAULT_VX,DEFAULT_VY); shotVelocity=0; lineTopLeftPos=0.
  - settle/timeout counters=0.
  - enterPrev=1, so an Enter held through reset does not fire.
- Enter edge: enterRise = keyEnter & ~enterPrev. enterPrev updates every clk in all states.
- States:
  - SETTLE: lineEnable=0.
    - On startOfFrame: if ballsMoving, counter clears to 0; else counter increments.
    - When counter reaches SETTLE_FRAMES: go to AIM. On entry, load velocity defaults and latch lineTopLeftPos from whiteBallPos.
  - AIM: lineEnable=1.
    - On each startOfFrame: re-latch lineTopLeftPos.
    - X update: X += AIM_STEP if keyRight only; X -= AIM_STEP if keyLeft only; no change if both or neither.
    - Y update: same rule with keyDown(+) / keyUp(-).
    - Arithmetic is done in 12-bit signed, then clamped to [-MAX_VEC, +MAX_VEC].
    - enterRise with aim vector (0,0): ignored, stay in AIM.
    - Otherwise enterRise: go to FIRE.
    - enterRise and startOfFrame in the same cycle: the fire wins and that frame's arrow update is dropped.
  - FIRE (exactly 1 cycle):
    - shotValid=1; shotVelocity = velocity >>> SHOT_SHIFT (sign-preserving).
    - lineEnable drops to 0 in this cycle. Go to WAIT_MOVE, counter=0.
  - WAIT_MOVE: lineEnable=0.
    - ballsMoving=1: go to SETTLE, counter=0.
    - On startOfFrame: counter increments. Reaching MOVE_TIMEOUT: go to SETTLE (covers a shot too weak to register).
- shotValid is high only in the FIRE cycle and never in two consecutive cycles. shotVelocity holds its value until the next FIRE.
- velocity outputs keep their last value outside AIM.
- Arrow keys are ignored outside AIM.
- Asserting resetN low in any state, including FIRE, returns all outputs to reset values immediately. No partial shot pulse survives reset.

Test Plan:
1. Reset release, ballsMoving=0 -> after 4 startOfFrame pulses: lineEnable=1, velocity=(64,0), lineTopLeftPos = whiteBallPos (e.g. 300,200).
2. In AIM, hold keyRight and keyUp for 10 frames -> velocity=(104,-40). Hold keyRight 50 more frames -> X clamps at 200. Press keyLeft and keyRight together -> X unchanged.
3. Steer to (-37,100), pulse Enter -> exactly one shotValid cycle with shotVelocity=(-10,25) (arithmetic shift); lineEnable=0 in the same cycle.
4. Steer to (0,0), press Enter -> no shotValid, remains AIM. Hold Enter through reset release -> no shot until released and re-pressed.
5. After a shot, raise ballsMoving 2 frames later, hold 30 frames, drop -> AIM re-entered 4 frames after the drop. A still frame mid-settle that is followed by ballsMoving=1 restarts the count. Never raising ballsMoving -> SETTLE after 8 frames, AIM after 4 more.
6. Enter rise coincident with startOfFrame while keyDown is held -> shot uses the pre-update vector; resetN pulsed during FIRE -> shotValid=0 asynchronously, state SETTLE.
